mult3_wb_stage: RTL and testbench

MULT3_WB_STAGE -- requirements
Module: mult3_wb_stage

---
 rtl/mult3_wb_stage_pkg.sv | 23 ++
 rtl/mult3_wb_if.sv | 43 ++++
 rtl/mult3_wb_stage_skid.sv | 85 ++++++++
 rtl/mult3_wb_stage.sv | 89 ++++++++
 tb/tb_mult3_wb_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult3_wb_stage_pkg.sv
// Shared defaults, buffer state encoding and the writeback entry layout
// for the third multiplier stage.
package vi_mult_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // One held op as it travels toward writeback.
    typedef struct packed {
        logic [XLEN_DEF-1:0]    data;
        logic [RADDR_W_DEF-1:0] addr;
        logic                   int_we;
        logic [XLEN_DEF-1:0]    instr;
        logic [XLEN_DEF-1:0]    pc;
    } wb_entry_t;

endpackage

// File: rtl/mult3_wb_if.sv
// Upstream (mult2->mult3) and writeback-port bundle for mult3_wb_stage.
interface mult3_wb_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) ();
    // upstream side
    logic               mult3_valid_i;
    logic [XLEN-1:0]    mult3_int_write_data_i;
    logic [XLEN-1:0]    mult3_partial_i;
    logic [RADDR_W-1:0] mult3_write_addr_i;
    logic               mult3_int_write_enable_i;
    logic [XLEN-1:0]    mult3_instruction_i;
    logic [XLEN-1:0]    mult3_pc_i;
    logic               mult3_stall_o;
    // writeback side
    logic               wb_ready_i;
    logic               wb_valid_o;
    logic [XLEN-1:0]    wb_int_write_data_o;
    logic [RADDR_W-1:0] wb_write_addr_o;
    logic               wb_int_write_enable_o;
    logic [XLEN-1:0]    wb_instruction_o;
    logic [XLEN-1:0]    wb_pc_o;

    // The stage itself
    modport slave (
        input  mult3_valid_i, mult3_int_write_data_i, mult3_partial_i,
               mult3_write_addr_i, mult3_int_write_enable_i,
               mult3_instruction_i, mult3_pc_i, wb_ready_i,
        output mult3_stall_o, wb_valid_o, wb_int_write_data_o,
               wb_write_addr_o, wb_int_write_enable_o, wb_instruction_o,
               wb_pc_o
    );

    // Whoever drives ops in and grants the writeback port
    modport master (
        output mult3_valid_i, mult3_int_write_data_i, mult3_partial_i,
               mult3_write_addr_i, mult3_int_write_enable_i,
               mult3_instruction_i, mult3_pc_i, wb_ready_i,
        input  mult3_stall_o, wb_valid_o, wb_int_write_data_o,
               wb_write_addr_o, wb_int_write_enable_o, wb_instruction_o,
               wb_pc_o
    );
endinterface

// File: rtl/mult3_wb_stage_skid.sv
// Two-entry in-order buffer: head is the output register, tail is the
// skid register that catches the op accepted while the head is blocked.
module mult_skid_buf
    import vi_mult_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t push_entry_i,
    output entry_t head_o,
    output entry_t tail_o,
    output logic   head_vld_o,
    output logic   tail_vld_o,
    output logic   full_o
);

    buf_state_e state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic       full_q, full_d;

    // Next-state and data movement; flush wins over push/pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    head_d  = push_entry_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push_i && pop_i) begin
                    head_d = push_entry_i;
                end else if (push_i) begin
                    tail_d  = push_entry_i;
                    state_d = BUF_FULL;
                end else if (pop_i) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // push cannot happen here: upstream sees stall
                if (pop_i) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end
        // stall is a flop that mirrors the FULL state
        full_d = (state_d == BUF_FULL);
    end

    // State, storage and registered stall; reset clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
        end
    end

    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign head_vld_o = (state_q != BUF_EMPTY);
    assign tail_vld_o = (state_q == BUF_FULL);
    assign full_o     = full_q;

endmodule

// File: rtl/mult3_wb_stage.sv
// Final multiplier stage: adds the two partial sums, buffers results in a
// 2-entry skid buffer toward writeback, and flags RAW hazards to decode.
module mult3_wb_stage
    import vi_mult_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    output logic               hazard_o,
    mult3_wb_if.slave          bus
);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]    data;
        logic [RADDR_W-1:0] addr;
        logic               int_we;
        logic [XLEN-1:0]    instr;
        logic [XLEN-1:0]    pc;
    } entry_t;

    logic   accept;
    logic   drain;
    entry_t new_entry;
    entry_t head;
    entry_t tail;
    logic   head_vld;
    logic   tail_vld;
    logic   full;

    assign accept = bus.mult3_valid_i && !bus.mult3_stall_o;
    assign drain  = bus.wb_valid_o && bus.wb_ready_i;

    // Sum is formed on the way in so the buffer holds final results;
    // the carry-out is dropped by the XLEN-wide assignment.
    always_comb begin
        new_entry        = '0;
        new_entry.data   = bus.mult3_int_write_data_i + bus.mult3_partial_i;
        new_entry.addr   = bus.mult3_write_addr_i;
        new_entry.int_we = bus.mult3_int_write_enable_i;
        new_entry.instr  = bus.mult3_instruction_i;
        new_entry.pc     = bus.mult3_pc_i;
    end

    mult_skid_buf #(
        .entry_t (entry_t)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_i       (accept),
        .pop_i        (drain),
        .push_entry_i (new_entry),
        .head_o       (head),
        .tail_o       (tail),
        .head_vld_o   (head_vld),
        .tail_vld_o   (tail_vld),
        .full_o       (full)
    );

    assign bus.mult3_stall_o         = full;
    assign bus.wb_valid_o            = head_vld;
    assign bus.wb_int_write_data_o   = head.data;
    assign bus.wb_write_addr_o       = head.addr;
    assign bus.wb_int_write_enable_o = head.int_we;
    assign bus.wb_instruction_o      = head.instr;
    assign bus.wb_pc_o               = head.pc;

    function automatic logic src_hit(input entry_t e, input logic vld,
                                     input logic [RADDR_W-1:0] rs1,
                                     input logic [RADDR_W-1:0] rs2);
        return vld && e.int_we && (e.addr != '0) &&
               ((e.addr == rs1) || (e.addr == rs2));
    endfunction

    // Hazard from any valid held entry; forced low while reset is asserted
    // so decode never sees stale state from before the reset.
    always_comb begin
        hazard_o = !rst_i &&
                   (src_hit(head, head_vld, rs1_addr_i, rs2_addr_i) ||
                    src_hit(tail, tail_vld, rs1_addr_i, rs2_addr_i));
    end

endmodule

// File: tb/tb_mult3_wb_stage.sv
// Directed bench for mult3_wb_stage: reset, streaming, backpressure,
// flush, hazard detection and mid-operation reset.
module tb_mult3_wb_stage;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic [4:0] rs1_addr_i;
    logic [4:0] rs2_addr_i;
    logic       hazard_o;

    int checks   = 0;
    int failures = 0;

    mult3_wb_if #(.XLEN(32), .RADDR_W(5)) bus ();

    mult3_wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .hazard_o   (hazard_o),
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input logic en,
                        input logic [31:0] instr, input logic [31:0] pc);
        bus.mult3_valid_i            = 1'b1;
        bus.mult3_int_write_data_i   = a;
        bus.mult3_partial_i          = b;
        bus.mult3_write_addr_i       = addr;
        bus.mult3_int_write_enable_i = en;
        bus.mult3_instruction_i      = instr;
        bus.mult3_pc_i               = pc;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(bus.wb_valid_o), 64'd0);
        check({tag, "_stall"}, 64'(bus.mult3_stall_o), 64'd0);
        check({tag, "_data"},  64'(bus.wb_int_write_data_o), 64'd0);
        check({tag, "_addr"},  64'(bus.wb_write_addr_o), 64'd0);
        check({tag, "_we"},    64'(bus.wb_int_write_enable_o), 64'd0);
        check({tag, "_instr"}, 64'(bus.wb_instruction_o), 64'd0);
        check({tag, "_pc"},    64'(bus.wb_pc_o), 64'd0);
        check({tag, "_hazard"}, 64'(hazard_o), 64'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] data,
                              input logic [4:0] addr, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(bus.wb_valid_o), 64'd1);
        check({tag, "_data"},  64'(bus.wb_int_write_data_o), 64'(data));
        check({tag, "_addr"},  64'(bus.wb_write_addr_o), 64'(addr));
        check({tag, "_pc"},    64'(bus.wb_pc_o), 64'(pc));
    endtask

    logic [31:0] sa  [4];
    logic [31:0] sb  [4];
    logic [31:0] sum [4];

    initial begin
        sa[0] = 32'hFFFF_FFFF; sb[0] = 32'h0000_0002; sum[0] = 32'h0000_0001;
        sa[1] = 32'h8000_0000; sb[1] = 32'h8000_0000; sum[1] = 32'h0000_0000;
        sa[2] = 32'h1234_5678; sb[2] = 32'h1111_1111; sum[2] = 32'h2345_6789;
        sa[3] = 32'h0000_000F; sb[3] = 32'h0000_0001; sum[3] = 32'h0000_0010;

        // Reset held two cycles with a valid op offered
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd0;
        bus.wb_ready_i = 1'b1;
        send(32'h5, 32'h6, 5'd7, 1'b1, 32'hAAAA, 32'hBBBB);
        tick();
        check_idle("rst1");
        tick();
        check_idle("rst2");
        rst_i = 1'b0;
        bus.mult3_valid_i = 1'b0;
        tick();
        check_idle("post_rst");

        // Streaming: four back-to-back ops, one per cycle, in order
        for (int i = 0; i < 4; i++) begin
            send(sa[i], sb[i], 5'(7 + i), 1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i));
            tick();
            check_head($sformatf("stream%0d", i), sum[i], 5'(7 + i), 32'h1000 + 32'(4 * i));
            check($sformatf("stream%0d_stall", i), 64'(bus.mult3_stall_o), 64'd0);
        end
        bus.mult3_valid_i = 1'b0;
        tick();
        check("stream_drained", 64'(bus.wb_valid_o), 64'd0);

        // Backpressure: P1, P2 fill the buffer, P3 waits upstream
        bus.wb_ready_i = 1'b0;
        send(32'd10, 32'd1, 5'd1, 1'b1, 32'h201, 32'h2000);
        tick();
        check_head("bp_p1", 32'd11, 5'd1, 32'h2000);
        check("bp_p1_stall", 64'(bus.mult3_stall_o), 64'd0);
        send(32'd20, 32'd2, 5'd2, 1'b1, 32'h202, 32'h2004);
        tick();
        check("bp_p2_stall", 64'(bus.mult3_stall_o), 64'd1);
        check_head("bp_p2_hold", 32'd11, 5'd1, 32'h2000);
        send(32'd30, 32'd3, 5'd3, 1'b1, 32'h203, 32'h2008);
        tick();
        check("bp_p3_stall", 64'(bus.mult3_stall_o), 64'd1);
        check_head("bp_p3_hold", 32'd11, 5'd1, 32'h2000);
        bus.wb_ready_i = 1'b1;
        tick();
        check_head("bp_out_p2", 32'd22, 5'd2, 32'h2004);
        check("bp_out_p2_stall", 64'(bus.mult3_stall_o), 64'd0);
        tick();
        check_head("bp_out_p3", 32'd33, 5'd3, 32'h2008);
        bus.mult3_valid_i = 1'b0;
        tick();
        check("bp_empty", 64'(bus.wb_valid_o), 64'd0);

        // Flush of a full buffer while a new op is offered
        bus.wb_ready_i = 1'b0;
        send(32'd1, 32'd1, 5'd4, 1'b1, 32'h301, 32'h3000);
        tick();
        send(32'd2, 32'd2, 5'd5, 1'b1, 32'h302, 32'h3004);
        tick();
        check("fl_full_stall", 64'(bus.mult3_stall_o), 64'd1);
        flush_i = 1'b1;
        send(32'd3, 32'd3, 5'd6, 1'b1, 32'h303, 32'h3008);
        tick();
        check("fl_valid", 64'(bus.wb_valid_o), 64'd0);
        check("fl_stall", 64'(bus.mult3_stall_o), 64'd0);
        flush_i = 1'b0;
        bus.mult3_valid_i = 1'b0;
        tick();
        check("fl_not_captured", 64'(bus.wb_valid_o), 64'd0);

        // Hazard: head op writes x5
        send(32'd0, 32'd0, 5'd5, 1'b1, 32'h401, 32'h4000);
        tick();
        bus.mult3_valid_i = 1'b0;
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd0; #1;
        check("hz_rs1", 64'(hazard_o), 64'd1);
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd5; #1;
        check("hz_rs2", 64'(hazard_o), 64'd1);
        rs1_addr_i = 5'd6; rs2_addr_i = 5'd4; #1;
        check("hz_miss", 64'(hazard_o), 64'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("hz_flushed", 64'(bus.wb_valid_o), 64'd0);

        // Destination x0 never hazards
        send(32'd0, 32'd0, 5'd0, 1'b1, 32'h402, 32'h4004);
        tick();
        bus.mult3_valid_i = 1'b0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; #1;
        check("hz_x0", 64'(hazard_o), 64'd0);
        check("hz_x0_valid", 64'(bus.wb_valid_o), 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;

        // Non-writing op retires through writeback but never hazards
        send(32'd0, 32'd0, 5'd5, 1'b0, 32'h403, 32'h4008);
        tick();
        bus.mult3_valid_i = 1'b0;
        rs1_addr_i = 5'd5; #1;
        check("hz_nowe", 64'(hazard_o), 64'd0);
        check("nowe_valid", 64'(bus.wb_valid_o), 64'd1);
        check("nowe_we", 64'(bus.wb_int_write_enable_o), 64'd0);
        bus.wb_ready_i = 1'b1;
        tick();
        check("nowe_retired", 64'(bus.wb_valid_o), 64'd0);

        // Tail entry also hazards; then reset a full buffer
        bus.wb_ready_i = 1'b0;
        send(32'd0, 32'd0, 5'd9, 1'b1, 32'h404, 32'h400C);
        tick();
        send(32'd0, 32'd0, 5'd12, 1'b1, 32'h405, 32'h4010);
        tick();
        bus.mult3_valid_i = 1'b0;
        rs1_addr_i = 5'd12; rs2_addr_i = 5'd0; #1;
        check("hz_tail", 64'(hazard_o), 64'd1);
        rs1_addr_i = 5'd9; #1;
        check("hz_head", 64'(hazard_o), 64'd1);
        rst_i = 1'b1;
        flush_i = 1'b1;
        bus.wb_ready_i = 1'b1;
        #1;
        check("hz_in_rst", 64'(hazard_o), 64'd0);
        tick();
        check_idle("midrst");
        rst_i = 1'b0;
        flush_i = 1'b0;
        tick();
        check_idle("midrst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
